// File: rtl/vga_fb_arb.sv
// Frame-memory arbiter: display reads take strict priority, and writer pixels are buffered and drained on blank cycles.
// Optional macro VGA_FB_ARB_STATS_EN enables the saturating writer-stall counter on stall_cnt.
module vga_fb_arb #(
    parameter int H_PIXELS   = 400,
    parameter int V_PIXELS   = 200,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [9:0]        col,
    input  logic [7:0]        row,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic [7:0]        stall_cnt,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ready_q, ready_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              pix_valid_q, pix_valid_d;
    logic [7:0]        pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic              display, full, empty, push, pop;

    // Write handshake: a pixel transfers on the rising edge where wr_valid and wr_ready are both high.
    always_comb begin
        display     = disp_ena && (32'(col) < H_PIXELS) && (32'(row) < V_PIXELS);
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        empty       = (count_q == '0);
        push        = wr_valid && ready_q && !full;
        pop         = !display && !empty;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        ready_d     = (count_d != CNT_W'(FIFO_DEPTH));
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (display) begin
            mem_en_d   = 1'b1;
            mem_addr_d = ADDR_W'(row) * ADDR_W'(H_PIXELS) + ADDR_W'(col);
        end else if (pop) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_addr[rd_ptr_q];
            mem_wdata_d = fifo_data[rd_ptr_q];
        end
        // Read data returns while the read command is on the bus, so it is captured one edge later.
        pix_valid_d = mem_en_q && !mem_we_q;
        pix_data_d  = pix_valid_d ? mem_rdata : pix_data_q;
        state_d     = state_q;
        case (state_q)
            ST_IDLE, ST_READ: begin
                if (display)     state_d = ST_READ;
                else if (!empty) state_d = ST_DRAIN;
                else             state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (display)                           state_d = ST_READ;
                else if (pop && count_d == '0)         state_d = ST_IDLE;
                else                                   state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [7:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst)                                        stall_q <= '0;
        else if (wr_valid && !ready_q && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 8'd0;
`endif

    assign wr_ready  = ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_vga_fb_arb.sv
// Bench for vga_fb_arb: table-driven display reads plus hand-written write-buffer, reset and stall sequences.
module tb_vga_fb_arb;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst, disp_ena, wr_valid, wr_ready;
  logic [9:0]        col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] wr_addr, mem_addr;
  logic [7:0]        wr_data, mem_wdata, mem_rdata, pix_data, stall_cnt;
  logic              mem_en, mem_we, pix_valid;
  logic [1:0]        dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  logic [ADDR_W+7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  vga_fb_arb dut (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .col(col), .row(row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // memory model: read data is a fixed function of the address on the bus
  assign mem_rdata = (mem_en && !mem_we) ? (mem_addr[7:0] ^ 8'hA5) : 8'h00;

  typedef struct {
    logic        disp;
    logic [7:0]  r;
    logic [9:0]  c;
    logic        exp_en;
    logic [16:0] exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one cycle, then check any issued write against the scoreboard
  task automatic step();
    logic [ADDR_W+7:0] e;
    @(posedge clk);
    #1;
    if (mem_en && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {7'd0, mem_addr, mem_wdata}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_cmd", {7'd0, mem_addr, mem_wdata}, {7'd0, e});
      end
    end
  endtask

  task automatic drive_blank();
    disp_ena = 1'b0; col = 10'd0; row = 8'd0;
  endtask

  task automatic drive_pix(input logic [7:0] r, input logic [9:0] c);
    disp_ena = 1'b1; row = r; col = c;
  endtask

  task automatic offer(input logic v, input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic accept);
    wr_valid = v; wr_addr = a; wr_data = d;
    if (v && accept) exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    drive_blank();
    step(); step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  vec_t vecs[7];
  logic [7:0] last_pix;

  initial begin
    vecs[0] = '{1'b1, 8'd3,   10'd5,   1'b1, 17'd1205};
    vecs[1] = '{1'b1, 8'd0,   10'd0,   1'b1, 17'd0};
    vecs[2] = '{1'b1, 8'd199, 10'd399, 1'b1, 17'd79999};
    vecs[3] = '{1'b1, 8'd3,   10'd400, 1'b0, 17'd0};
    vecs[4] = '{1'b1, 8'd200, 10'd7,   1'b0, 17'd0};
    vecs[5] = '{1'b0, 8'd3,   10'd5,   1'b0, 17'd0};
    vecs[6] = '{1'b1, 8'd10,  10'd399, 1'b1, 17'd4399};

    // reset state, sampled while rst is still high
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    drive_blank();
    step();
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_data", {24'd0, pix_data}, 32'd0);
    chk("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, wr_ready}, 32'd1);
    chk("blank_empty_no_en", {31'd0, mem_en}, 32'd0);

    // table-driven display reads
    last_pix = 8'h00;
    for (int i = 0; i < 7; i++) begin
      disp_ena = vecs[i].disp; row = vecs[i].r; col = vecs[i].c;
      step();
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, 32'd0);
        chk($sformatf("v%0d_mem_addr", i), {15'd0, mem_addr}, {15'd0, vecs[i].exp_addr});
      end
      drive_blank();
      step();
      chk($sformatf("v%0d_pix_valid", i), {31'd0, pix_valid}, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en) last_pix = vecs[i].exp_addr[7:0] ^ 8'hA5;
      chk($sformatf("v%0d_pix_data", i), {24'd0, pix_data}, {24'd0, last_pix});
      step();
      chk($sformatf("v%0d_pix_drop", i), {31'd0, pix_valid}, 32'd0);
    end

    // back-to-back reads along a line: no bubbles
    for (int c = 0; c < 6; c++) begin
      drive_pix(8'd1, 10'(c));
      step();
      if (c >= 1) chk($sformatf("line_pix_valid_%0d", c), {31'd0, pix_valid}, 32'd1);
      if (c >= 1) chk($sformatf("line_pix_data_%0d", c), {24'd0, pix_data}, {24'd0, 8'(400 + c - 1) ^ 8'hA5});
    end
    drive_blank();
    step(); step();

    // six writes offered during an active line: four accepted, none issued until blank
    for (int i = 0; i < 6; i++) begin
      drive_pix(8'd2, 10'(i));
      chk($sformatf("wr_ready_%0d", i), {31'd0, wr_ready}, {31'd0, (i < 4)});
      offer(1'b1, 17'(100 + i), 8'(8'h30 + i), i < 4);
      step();
      chk($sformatf("no_we_in_disp_%0d", i), {31'd0, mem_we}, 32'd0);
    end
    offer(1'b0, '0, '0, 1'b0);
    drive_pix(8'd2, 10'd6);
    step();
    chk("still_no_we", {31'd0, mem_we}, 32'd0);
    drive_blank();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain_we_%0d", i), {31'd0, mem_we && mem_en}, 32'd1);
    end
    step();
    chk("drain_done_en", {31'd0, mem_en}, 32'd0);
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    // blank with two queued plus a simultaneous push+pop
    drive_pix(8'd5, 10'd0);
    offer(1'b1, 17'd500, 8'hA0, 1'b1);
    step();
    drive_pix(8'd5, 10'd1);
    offer(1'b1, 17'd501, 8'hA1, 1'b1);
    step();
    drive_blank();
    chk("pp_ready", {31'd0, wr_ready}, 32'd1);
    offer(1'b1, 17'd502, 8'hA2, 1'b1);
    step();
    chk("pp_we_next", {31'd0, mem_we}, 32'd1);
    chk("pp_ready_after", {31'd0, wr_ready}, 32'd1);
    offer(1'b0, '0, '0, 1'b0);
    step();
    chk("pp_we_2", {31'd0, mem_we}, 32'd1);
    step();
    chk("pp_we_3", {31'd0, mem_we}, 32'd1);
    step();
    chk("pp_idle", {31'd0, mem_en}, 32'd0);
    chk("pp_queue_empty", exp_q.size(), 32'd0);

    // reset mid-line with three queued writes
    for (int i = 0; i < 3; i++) begin
      drive_pix(8'd7, 10'(i));
      offer(1'b1, 17'(700 + i), 8'(i), 1'b0);
      step();
    end
    offer(1'b0, '0, '0, 1'b0);
    drive_pix(8'd7, 10'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
    rst = 1'b0;
    drive_blank();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst_en_%0d", i), {31'd0, mem_en}, 32'd0);
      chk($sformatf("post_rst_pv_%0d", i), {31'd0, pix_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, wr_ready}, 32'd1);

    // writer stalls for 300 cycles against a full buffer during display
    for (int i = 0; i < 304; i++) begin
      drive_pix(8'd9, 10'(i % 400));
      offer(1'b1, 17'(900 + i), 8'(i), i < 4);
      step();
    end
`ifdef VGA_FB_ARB_STATS_EN
    chk("stall_cnt_sat", {24'd0, stall_cnt}, 32'd255);
`else
    chk("stall_cnt_off", {24'd0, stall_cnt}, 32'd0);
`endif
    offer(1'b0, '0, '0, 1'b0);
    drive_blank();
    for (int i = 0; i < 6; i++) step();
    chk("stall_drain_empty", exp_q.size(), 32'd0);

    do_reset();
    chk("final_stall_cnt", {24'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_arb.md
VGA_FB_ARB -- requirements
Module: vga_fb_arb

Interface
REQ-001 SHALL have parameter H_PIXELS, default 400, visible columns per line.
REQ-002 SHALL have parameter V_PIXELS, default 200, visible rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-memory address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port disp_ena, input, 1, timing generator in visible region.
REQ-008 SHALL have port col, input, 10, current visible column.
REQ-009 SHALL have port row, input, 8, current visible row.
REQ-010 SHALL have port wr_valid, input, 1, writer offers a pixel.
REQ-011 SHALL have port wr_ready, output, 1, write accepted when wr_valid&wr_ready.
REQ-012 SHALL have port wr_addr, input, ADDR_W, writer pixel address.
REQ-013 SHALL have port wr_data, input, 8, writer pixel value.
REQ-014 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 8): single-port frame-memory command, all registered.
REQ-015 SHALL have port mem_rdata, input, 8, read data valid the cycle after mem_en&!mem_we.
REQ-016 SHALL have ports pix_valid (output, 1) and pix_data (output, 8): registered pixel to display.
REQ-017 SHALL have port stall_cnt, output, 8, writer stall statistic (see Configuration).

Function
REQ-018 SHALL arbitrate one memory port between display reads (strict priority) and buffered writes.
REQ-019 SHALL treat a cycle as a display cycle iff disp_ena=1 and col<H_PIXELS and row<V_PIXELS; otherwise as blank.
REQ-020 SHALL, for a display cycle sampled at edge N, drive at N+1 mem_en=1, mem_we=0, mem_addr=row*H_PIXELS+col (computed at ADDR_W bits, no truncation for legal row/col).
REQ-021 SHALL register mem_rdata into pix_data with pix_valid=1 at edge N+2; fixed latency 2, no bubbles across a line.
REQ-022 SHALL hold a FIFO of FIFO_DEPTH {addr,data} entries; wr_ready = !full; push on wr_valid&wr_ready.
REQ-023 SHALL, on a blank cycle with FIFO non-empty, pop head and drive mem_en=1, mem_we=1, mem_addr/mem_wdata=head next edge.
REQ-024 SHALL never issue a write in a display cycle; FIFO holds its contents.
REQ-025 SHALL allow push and pop in one cycle when non-empty and not full; count unchanged.
REQ-026 SHALL, when full, deassert wr_ready; no push even if a pop occurs that cycle.
REQ-027 SHALL drive mem_en=0 when blank and FIFO empty.
REQ-028 SHALL implement FSM IDLE/READ/DRAIN: IDLE->READ on display cycle; IDLE->DRAIN on blank & non-empty; READ->DRAIN on blank & non-empty; READ->IDLE on blank & empty; DRAIN->READ on display cycle; DRAIN->IDLE on blank & pop of last entry.
REQ-029 SHALL keep pix_data unchanged when pix_valid=0.

Reset
REQ-030 SHALL, on rst=1 at an edge, set state IDLE, FIFO empty, wr_ready=0 that cycle then 1 after, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_valid=0, pix_data=0, stall_cnt=0.
REQ-031 SHALL discard any in-flight read or queued write when reset occurs mid-operation; no pix_valid pulse follows.

Configuration
REQ-032 SHALL compile the stall counter only when macro VGA_FB_ARB_STATS_EN is defined: stall_cnt increments on each cycle wr_valid=1&wr_ready=0, saturating at 255.
REQ-033 SHALL, without VGA_FB_ARB_STATS_EN, tie stall_cnt to 0; all other behaviour identical.

Verification
REQ-034 SHALL cover: disp_ena=1, row=3, col=5 -> mem_addr=1205 at N+1, pix_valid at N+2 with pix_data=mem_rdata.
REQ-035 SHALL cover: 6 writes offered during active line -> 4 accepted, wr_ready=0 after 4th, none issued until first blank cycle, then 4 consecutive mem_we pulses in order.
REQ-036 SHALL cover: blank, FIFO at 2, simultaneous push+pop -> count stays 2, mem_we=1 next edge.
REQ-037 SHALL cover: disp_ena=1 with col=400 -> no mem_en, treated as blank.
REQ-038 SHALL cover: rst asserted mid-line with FIFO at 3 -> next cycle mem_en=0, pix_valid=0, FIFO empty, no writes issued.
REQ-039 SHALL cover: with VGA_FB_ARB_STATS_EN, 300 stalled cycles -> stall_cnt=255; without macro -> stall_cnt=0.
